// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: fetch sequencer between a small combinational instruction
// ROM and the vending datapath. Walks the ROM from START_ADDR, hands each
// word over a valid/ready handshake, and stops at the end-marker word (or
// on address wrap, flagged by the sticky overrun) with a one-cycle done.
// Optional build macro: INST_FETCH_ABORT_EN adds an abort input that
// returns the sequencer to IDLE without a done pulse.
module inst_fetch_seq #(
  parameter int unsigned AW         = 3,
  parameter int unsigned IW         = 19,
  parameter int unsigned START_ADDR = 1,
  parameter logic [3:0]  END_OP     = 4'h7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef INST_FETCH_ABORT_EN
  input  logic          abort,
`endif
  output logic [AW-1:0] rom_addr,
  input  logic [IW-1:0] rom_dout,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  localparam int unsigned MW = 7;
  // End marker: opcode field high bits followed by an all-ones nibble.
  localparam logic [MW-1:0] MARKER    = {END_OP[2:0], 4'hF};
  localparam logic [AW-1:0] FIRST     = AW'(START_ADDR);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state;
  logic   is_marker;

  // Marker decode on the live ROM word.
  assign is_marker = (rom_dout[IW-1 -: MW] == MARKER);

  // A program is in flight whenever the sequencer is out of IDLE.
  assign busy = (state != IDLE);

  // Sequencer state, address walk, instruction latch and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done <= 1'b0;
`ifdef INST_FETCH_ABORT_EN
      if (abort) begin
        // Abort wins over start and instr_ready; overrun is left as is.
        if (state != IDLE) begin
          state       <= IDLE;
          instr_valid <= 1'b0;
          rom_addr    <= '0;
        end
      end else
`endif
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr <= FIRST;
            overrun  <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (is_marker) begin
            state <= FIN;
          end else begin
            instr       <= rom_dout;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            // Wrap is caught before the increment so it is never silent.
            if (rom_addr == LAST_ADDR) begin
              overrun  <= 1'b1;
              rom_addr <= '0;
              state    <= FIN;
            end else begin
              rom_addr <= rom_addr + AW'(1);
              state    <= FETCH;
            end
          end
        end
        FIN: begin
          done     <= 1'b1;
          rom_addr <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq: per-cycle vector table for a nominal
// program, then hand-written sequences for stall, empty program, overrun,
// ignored start, mid-program reset and (when built in) abort.
module tb_inst_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  rom_addr;
  logic [18:0] rom_dout;
  logic [18:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        done;
  logic        overrun;
`ifdef INST_FETCH_ABORT_EN
  logic        abort;
`endif

  logic [18:0] rom [0:7];
  logic [18:0] issued [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_dout = rom[rom_addr];

  inst_fetch_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef INST_FETCH_ABORT_EN
    .abort       (abort),
`endif
    .rom_addr    (rom_addr),
    .rom_dout    (rom_dout),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic [2:0]  addr;
    logic        iv;
    logic [18:0] instr;
    logic        busy;
    logic        done;
    logic        ovr;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    rom[0] = 19'h7f000;
    rom[1] = 19'h72006;
    rom[2] = 19'h73004;
    rom[3] = 19'h52230;
    rom[4] = 19'h32230;
    rom[5] = 19'h04240;
    rom[6] = 19'h7f000;
    rom[7] = 19'h7f000;
  endtask

  // Bounded wait until the sequencer shows the given address/valid pair.
  task automatic wait_for(input string nm, input logic [2:0] a, input logic v);
    int c;
    c = 0;
    while (!(rom_addr == a && instr_valid == v) && c < 60) begin
      tick();
      c++;
    end
    n_checks++;
    if (c >= 60) begin
      n_fail++;
      $display("FAIL %s: timeout waiting for addr %0d valid %0d", nm, a, v);
    end
  endtask

  // Run until busy drops, logging handshakes, busy cycles and done pulses.
  task automatic drain(input string nm, inout int nb, output int nd);
    int c;
    c  = 0;
    nd = 0;
    while (c < 100) begin
      if (instr_valid && instr_ready) issued.push_back(instr);
      tick();
      c++;
      if (busy) nb++;
      if (done) nd++;
      if (!busy) break;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s: timeout, still busy", nm);
    end
  endtask

  task automatic run_prog(input string nm, output int nb, output int nd);
    issued.delete();
    nb    = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy) nb++;
    drain(nm, nb, nd);
  endtask

  task automatic chk_issued(input string nm, input logic [18:0] exp [$]);
    chk({nm, "_count"}, 32'(issued.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < issued.size(); i++)
      chk($sformatf("%s_word%0d", nm, i), 32'(issued[i]), 32'(exp[i]));
  endtask

  initial begin
    int          nb;
    int          nd;
    logic [18:0] full_prog [$];
    logic [18:0] tail_prog [$];
    logic [18:0] none [$];
    logic [18:0] wrap_prog [$];

    full_prog = '{19'h72006, 19'h73004, 19'h52230, 19'h32230, 19'h04240};
    tail_prog = '{19'h52230, 19'h32230, 19'h04240};

    // start ready addr iv instr busy done ovr, outputs seen after each edge
    tbl[0]  = '{1'b1, 1'b1, 3'd1, 1'b0, 19'h00000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 3'd1, 1'b1, 19'h72006, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 3'd2, 1'b0, 19'h72006, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 3'd2, 1'b1, 19'h73004, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 3'd3, 1'b0, 19'h73004, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 3'd3, 1'b1, 19'h52230, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 3'd4, 1'b0, 19'h52230, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 3'd4, 1'b1, 19'h32230, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 3'd5, 1'b0, 19'h32230, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'd5, 1'b1, 19'h04240, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'd6, 1'b0, 19'h04240, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 3'd6, 1'b0, 19'h04240, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 3'd0, 1'b0, 19'h04240, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 3'd0, 1'b0, 19'h04240, 1'b0, 1'b0, 1'b0};

    load_prog();
    rst_n       = 1'b0;
    start       = 1'b0;
    instr_ready = 1'b0;
`ifdef INST_FETCH_ABORT_EN
    abort       = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal program, ready held high, cycle by cycle.
    for (int i = 0; i < 14; i++) begin
      start       = tbl[i].start;
      instr_ready = tbl[i].ready;
      tick();
      chk($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
      chk($sformatf("v%0d_instr", i), 32'(instr), 32'(tbl[i].instr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("v%0d_overrun", i), 32'(overrun), 32'(tbl[i].ovr));
    end
    start = 1'b0;

    // Stall four cycles on word 3.
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for("stall_reach", 3'd3, 1'b1);
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stall%0d_instr", i), 32'(instr), 32'h52230);
      chk($sformatf("stall%0d_valid", i), 32'(instr_valid), 32'd1);
      chk($sformatf("stall%0d_addr", i), 32'(rom_addr), 32'd3);
    end
    instr_ready = 1'b1;
    issued.delete();
    nb = 0;
    drain("stall_drain", nb, nd);
    chk_issued("stall", tail_prog);
    chk("stall_done", 32'(nd), 32'd1);

    // Empty program: marker at the first address.
    rom[1] = 19'h7f000;
    run_prog("empty", nb, nd);
    chk_issued("empty", none);
    chk("empty_busy_cycles", 32'(nb), 32'd2);
    chk("empty_done", 32'(nd), 32'd1);
    tick();
    chk("empty_done_single", 32'(done), 32'd0);

    // No marker anywhere in words 1..7: wrap flagged as overrun.
    for (int i = 1; i < 8; i++) begin
      rom[i] = 19'h10000 + 19'(i);
      wrap_prog.push_back(19'h10000 + 19'(i));
    end
    run_prog("wrap", nb, nd);
    chk_issued("wrap", wrap_prog);
    chk("wrap_busy_cycles", 32'(nb), 32'd15);
    chk("wrap_done", 32'(nd), 32'd1);
    chk("wrap_overrun", 32'(overrun), 32'd1);
    chk("wrap_addr", 32'(rom_addr), 32'd0);
    tick();
    chk("wrap_overrun_sticky", 32'(overrun), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_clears_overrun", 32'(overrun), 32'd0);
    chk("restart_addr", 32'(rom_addr), 32'd1);
    nb = 0;
    drain("wrap2_drain", nb, nd);

    // Start while busy is ignored; reset mid-program clears everything.
    load_prog();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for("busy_start_reach", 3'd2, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_addr", 32'(rom_addr), 32'd3);
    chk("busy_start_busy", 32'(busy), 32'd1);
    tick();
    chk("busy_start_instr", 32'(instr), 32'h52230);
    wait_for("reset_reach", 3'd4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("postrst%0d_done", i), 32'(done), 32'd0);
      chk($sformatf("postrst%0d_valid", i), 32'(instr_valid), 32'd0);
    end
    run_prog("fresh", nb, nd);
    chk_issued("fresh", full_prog);
    chk("fresh_done", 32'(nd), 32'd1);
    chk("fresh_overrun", 32'(overrun), 32'd0);

`ifdef INST_FETCH_ABORT_EN
    // Abort while word 2 is held in ISSUE; abort beats instr_ready.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for("abort_reach", 3'd2, 1'b0);
    instr_ready = 1'b0;
    tick();
    chk("abort_pre_instr", 32'(instr), 32'h73004);
    chk("abort_pre_valid", 32'(instr_valid), 32'd1);
    abort       = 1'b1;
    instr_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(instr_valid), 32'd0);
    chk("abort_addr", 32'(rom_addr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_done_after", 32'(done), 32'd0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_blocks_start", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
